sram_dual_port_ctrl: RTL

// - Two-requester arbiter + controller for one asynchronous 32-bit SRAM bank.
// - Port 0 = data/MEM stage, port 1 = instruction fetch; req/ack handshake replaces stop_n stalls.
// - Byte/half/word accesses with programmable read/write wait states.
// - Sits between the CPU memory stages and the board SRAM pins.

---
 rtl/sram_dual_port_ctrl_if.sv | 23 ++
 rtl/sram_dual_port_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_dual_port_ctrl_if.sv
// Requester-side bus for one port of the dual-port SRAM controller.
// The master drives the request fields; the slave (controller) returns ack and read data.
interface sram_dual_port_ctrl_if #(
  parameter int ADDR_W = 22
);
  logic              req;
  logic              we;
  logic [1:0]        size;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              ack;

  modport master (
    output req, we, size, addr, wdata,
    input  rdata, ack
  );

  modport slave (
    input  req, we, size, addr, wdata,
    output rdata, ack
  );
endinterface

// File: rtl/sram_dual_port_ctrl.sv
// Two-requester arbiter and wait-state controller for one asynchronous 32-bit SRAM bank.
// Define SRAM_RR_ARB_EN for round-robin arbitration; otherwise port 0 has fixed priority.
//
// state  | meaning
// IDLE   | strobes released, sample requests and latch the winner
// ACCESS | ce_n low with oe_n (read) or we_n (write) low for WAIT+1 cycles
// DONE   | strobes released, write data held, winner's ack pulses
module sram_dual_port_ctrl #(
  parameter int ADDR_W  = 22,
  parameter int RD_WAIT = 1,
  parameter int WR_WAIT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  sram_dual_port_ctrl_if.slave p0,
  sram_dual_port_ctrl_if.slave p1,
  output logic                 busy,
  inout  wire  [31:0]          ram_data,
  output logic [ADDR_W-3:0]    ram_addr,
  output logic [3:0]           ram_be_n,
  output logic                 ram_ce_n,
  output logic                 ram_oe_n,
  output logic                 ram_we_n
);

  localparam logic [3:0] RD_CNT = 4'(RD_WAIT);
  localparam logic [3:0] WR_CNT = 4'(WR_WAIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;

  // 0 = port 0, 1 = port 1
  logic grant;
  logic owner;

  logic              lat_we;
  logic [1:0]        lat_size;
  logic [ADDR_W-1:0] lat_addr;
  logic [31:0]       lat_wdata;

  logic              cur_we;
  logic [1:0]        cur_size;
  logic [ADDR_W-1:0] cur_addr;
  logic [31:0]       cur_wdata;

  logic              drive, drive_nxt;
  logic [31:0]       dout, dout_nxt;
  logic              ce_n_nxt, oe_n_nxt, we_n_nxt;
  logic [3:0]        be_n_nxt;
  logic [ADDR_W-3:0] addr_nxt;
  logic              ack0, ack1, ack0_nxt, ack1_nxt;
  logic [31:0]       rdata0, rdata1;

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'b00:   lane_mask = 4'b0001 << lo;
      2'b01:   lane_mask = lo[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] wr_replicate(input logic [1:0] size, input logic [31:0] w);
    case (size)
      2'b00:   wr_replicate = {4{w[7:0]}};
      2'b01:   wr_replicate = {2{w[15:0]}};
      default: wr_replicate = w;
    endcase
  endfunction

  function automatic logic [31:0] rd_align(input logic [1:0] size, input logic [1:0] lo,
                                           input logic [31:0] d);
    case (size)
      2'b00:   rd_align = {24'h0, d[{lo, 3'b000} +: 8]};
      2'b01:   rd_align = lo[1] ? {16'h0, d[31:16]} : {16'h0, d[15:0]};
      default: rd_align = d;
    endcase
  endfunction

`ifdef SRAM_RR_ARB_EN
  logic last_served;

  always_comb begin
    grant = ~p0.req;
    if (p0.req && p1.req) grant = ~last_served;
  end

  always_ff @(posedge clk) begin
    if (rst)                last_served <= 1'b1;
    else if (state == DONE) last_served <= owner;
  end
`else
  // Port 0 wins any contention; port 1 only wins when port 0 is quiet.
  always_comb begin
    grant = ~p0.req;
  end
`endif

  // Fields come straight from the winning port in IDLE, from the latch afterwards.
  always_comb begin
    if (state == IDLE) begin
      cur_we    = grant ? p1.we    : p0.we;
      cur_size  = grant ? p1.size  : p0.size;
      cur_addr  = grant ? p1.addr  : p0.addr;
      cur_wdata = grant ? p1.wdata : p0.wdata;
    end else begin
      cur_we    = lat_we;
      cur_size  = lat_size;
      cur_addr  = lat_addr;
      cur_wdata = lat_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      ram_ce_n  <= 1'b1;
      ram_oe_n  <= 1'b1;
      ram_we_n  <= 1'b1;
      ram_be_n  <= 4'hF;
      ram_addr  <= '0;
      drive     <= 1'b0;
      dout      <= '0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      ram_ce_n  <= ce_n_nxt;
      ram_oe_n  <= oe_n_nxt;
      ram_we_n  <= we_n_nxt;
      ram_be_n  <= be_n_nxt;
      ram_addr  <= addr_nxt;
      drive     <= drive_nxt;
      dout      <= dout_nxt;
      ack0      <= ack0_nxt;
      ack1      <= ack1_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (p0.req || p1.req) begin
          state_nxt = ACCESS;
          cnt_nxt   = cur_we ? WR_CNT : RD_CNT;
        end
      end
      ACCESS: begin
        if (cnt == 4'd0) state_nxt = DONE;
        else             cnt_nxt   = cnt - 4'd1;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Pins are registered, so this decodes the state being entered.
  always_comb begin
    ce_n_nxt  = 1'b1;
    oe_n_nxt  = 1'b1;
    we_n_nxt  = 1'b1;
    be_n_nxt  = 4'hF;
    addr_nxt  = ram_addr;
    drive_nxt = 1'b0;
    dout_nxt  = dout;
    ack0_nxt  = 1'b0;
    ack1_nxt  = 1'b0;
    case (state_nxt)
      ACCESS: begin
        ce_n_nxt  = 1'b0;
        oe_n_nxt  = cur_we;
        we_n_nxt  = ~cur_we;
        be_n_nxt  = ~lane_mask(cur_size, cur_addr[1:0]);
        addr_nxt  = cur_addr[ADDR_W-1:2];
        drive_nxt = cur_we;
        dout_nxt  = wr_replicate(cur_size, cur_wdata);
      end
      DONE: begin
        be_n_nxt  = ram_be_n;
        drive_nxt = lat_we;
        ack0_nxt  = ~owner;
        ack1_nxt  = owner;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner     <= 1'b0;
      lat_we    <= 1'b0;
      lat_size  <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rdata0    <= '0;
      rdata1    <= '0;
    end else begin
      if (state == IDLE && state_nxt == ACCESS) begin
        owner     <= grant;
        lat_we    <= cur_we;
        lat_size  <= cur_size;
        lat_addr  <= cur_addr;
        lat_wdata <= cur_wdata;
      end
      if (state == ACCESS && state_nxt == DONE && !lat_we) begin
        if (owner) rdata1 <= rd_align(lat_size, lat_addr[1:0], ram_data);
        else       rdata0 <= rd_align(lat_size, lat_addr[1:0], ram_data);
      end
    end
  end

  assign busy     = (state != IDLE);
  assign ram_data = drive ? dout : 32'bz;
  assign p0.ack   = ack0;
  assign p1.ack   = ack1;
  assign p0.rdata = rdata0;
  assign p1.rdata = rdata1;

endmodule
